// File: rtl/byte_lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit.
//   - funct3 access-type codes (B, H, W, BU, HU)
//   - FSM state encoding
//   - helpers: byte count per access, request legality, store-data alignment
package byte_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of single-byte memory transfers for an access type.
    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

    // A request is legal when exactly one of read/write is set and the
    // access type exists for that direction (stores have no unsigned forms).
    function automatic logic req_legal(input logic rd, input logic wr, input logic [2:0] f3);
        logic ok;
        if (rd == wr) begin
            ok = 1'b0;
        end else if (rd) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return ok;
    endfunction

    // Left-justify the bytes to be stored so the first byte sent (the most
    // significant one, big-endian) always sits in bits [31:24].
    function automatic logic [31:0] align_store(input logic [31:0] data, input logic [2:0] f3);
        case (byte_count(f3))
            3'd1:    return {data[7:0], 24'h0};
            3'd2:    return {data[15:0], 16'h0};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result extension.
//   acc    : assembled load bytes, right-justified
//   nbytes : 1, 2 or 4 valid bytes in acc
//   funct3 : access type; B/H sign-extend, BU/HU zero-extend, W unchanged
//   result : 32-bit extended value
module load_extend
    import byte_lsu_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [2:0]  nbytes,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic sext;
    assign sext = (funct3 == F3_B) || (funct3 == F3_H);

    always_comb begin
        case (nbytes)
            3'd1:    result = {{24{sext & acc[7]}},  acc[7:0]};
            3'd2:    result = {{16{sext & acc[15]}}, acc[15:0]};
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/byte_lsu.sv
// Byte-serial load/store initiator.
// Accepts one load/store request from the core and issues it as 1, 2 or 4
// single-byte memory transfers, big-endian (byte at addr is the MSB).
//   clk, rst_n                  : clock, synchronous active-low reset
//   start, MemRead, MemWrite,
//   funct3, addr, data_in       : request (sampled only in IDLE)
//   data_out, busy, done, err   : result, status, completion pulse, illegal flag
//   mem_addr, mem_re, mem_we,
//   mem_wdata, mem_rdata, mem_ack : byte-wide memory port
module byte_lsu
    import byte_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;   // store bytes, next one in [31:24]
    logic [2:0]        n_q, n_d;           // bytes in this access
    logic [1:0]        idx_q, idx_d;       // byte counter
    logic [31:0]       acc_q, acc_d;       // load bytes shifted in LSB-first
    logic [31:0]       dout_q, dout_d;
    logic              err_q, err_d;

    logic [31:0]       acc_shift;
    logic [31:0]       load_result;
    logic              last_byte;

    assign acc_shift = {acc_q[23:0], mem_rdata};
    assign last_byte = ({1'b0, idx_q} == (n_q - 3'd1));

    // Extend using the value that will be in acc after the final ack, so
    // data_out is already valid in the DONE cycle.
    load_extend u_load_extend (
        .acc    (acc_shift),
        .nbytes (n_q),
        .funct3 (f3_q),
        .result (load_result)
    );

    // Memory port: driven only while transferring, zero otherwise.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (state_q == XFER) begin
            mem_re    = rd_q;
            mem_we    = wr_q;
            mem_addr  = addr_q + ADDR_W'(idx_q);  // wraps modulo 2^ADDR_W
            mem_wdata = wr_q ? wdata_q[31:24] : 8'h00;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign data_out = dout_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = align_store(data_in, funct3);
                    n_d     = byte_count(funct3);
                    idx_d   = 2'd0;
                    acc_d   = 32'h0;
                    if (req_legal(MemRead, MemWrite, funct3)) begin
                        err_d   = 1'b0;
                        state_d = XFER;
                    end else begin
                        // Illegal: skip memory entirely and report.
                        err_d   = 1'b1;
                        dout_d  = 32'h0;
                        state_d = DONE;
                    end
                end
            end

            XFER: begin
                // Request stays stable until ack; each ack retires one byte.
                if (mem_ack) begin
                    acc_d   = acc_shift;
                    wdata_d = {wdata_q[23:0], 8'h00};
                    idx_d   = idx_q + 2'd1;
                    if (last_byte) begin
                        idx_d   = 2'd0;
                        state_d = DONE;
                        if (rd_q) begin
                            dout_d = load_result;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // Every register is reset (there is no array storage here), which also forces all outputs to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            n_q     <= 3'd0;
            idx_q   <= 2'd0;
            acc_q   <= 32'h0;
            dout_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_byte_lsu.sv
// Self-checking bench for byte_lsu: byte memory model with configurable wait
// states, transfer monitor, and a behavioural model of load/store results.
module tb_byte_lsu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    byte_lsu #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory seen by the DUT and the model's own copy.
    logic [7:0]  mem     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    // Monitor logs for the current request.
    logic [39:0] wlog[$];        // {addr, byte} of acked writes
    logic [31:0] acc_addr_q[$];  // addresses of acked transfers
    bit          any_access;
    int          stab_err;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [1:0]  prev_rw;
    logic [7:0]  prev_wd;

    int          wait_cfg = 0;
    bit          hold_ack = 0;
    int          wcnt = 0;

    int          obs_cyc;
    logic [31:0] obs_dout;
    logic        obs_err;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        mem[a]     = b;
        ref_mem[a] = b;
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_n(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3);
        if (rd == wr) return 1'b0;
        if (rd) return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    endfunction

    // Big-endian value of n bytes, then sign-extended for LB/LH by subtracting 2^(8n).
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        longint v;
        int     n;
        v = 0;
        n = ref_n(f3);
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_rd(a + 32'(i)));
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- memory responder ----------------
    always @(negedge clk) begin
        if (hold_ack) begin
            mem_ack = 1'b0;
        end else if (mem_re || mem_we) begin
            if (wcnt < wait_cfg) begin
                mem_ack = 1'b0;
                wcnt++;
            end else begin
                mem_ack = 1'b1;
                wcnt = 0;
            end
        end else begin
            mem_ack = 1'($urandom);   // stray acks outside a transfer
            wcnt = 0;
        end
        mem_rdata = mem_re ? mem_rd(mem_addr) : 8'($urandom);
    end

    always @(posedge clk) begin
        if (mem_re || mem_we) begin
            any_access = 1'b1;
            if (prev_wait && (mem_addr !== prev_addr || {mem_re, mem_we} !== prev_rw || mem_wdata !== prev_wd))
                stab_err++;
            if (mem_ack) begin
                acc_addr_q.push_back(mem_addr);
                if (mem_we) begin
                    wlog.push_back({mem_addr, mem_wdata});
                    mem[mem_addr] = mem_wdata;
                end
            end
            prev_wait = !mem_ack;
            prev_addr = mem_addr;
            prev_rw   = {mem_re, mem_we};
            prev_wd   = mem_wdata;
        end else begin
            prev_wait = 1'b0;
        end
    end

    // Issue one request; obs_cyc = cycle of done (accept edge = 0), -1 on timeout.
    task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input bit hold_start);
        wlog.delete();
        acc_addr_q.delete();
        any_access = 1'b0;
        prev_wait  = 1'b0;
        stab_err   = 0;
        @(negedge clk);
        start = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; data_in = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) begin
            start = 1'b0;
            MemRead = 1'($urandom); MemWrite = 1'($urandom); funct3 = 3'($urandom);
            addr = $urandom; data_in = $urandom;
        end
        obs_cyc = 1;
        while (done !== 1'b1 && obs_cyc < 300) begin
            @(negedge clk);
            obs_cyc++;
        end
        if (done !== 1'b1) obs_cyc = -1;
        obs_dout = data_out;
        obs_err  = err;
        start = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        addr = 32'h10; data_in = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, mem_re, mem_we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, err, mem_re, mem_we});
        end
        n_checks++;
        if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5];
        logic [31:0] exps [5];
        int          cycs [5];
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012, 32'h80123456};
        cycs = '{2, 2, 3, 3, 5};
        preload(32'h10, 8'h80); preload(32'h11, 8'h12);
        preload(32'h12, 8'h34); preload(32'h13, 8'h56);
        wait_cfg = 0;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1, 1'b0, f3s[i], 32'h10, $urandom, 1'b0);
            n_checks++;
            if (obs_dout !== exps[i]) begin n_fail++; $display("FAIL load_f3_%0b_data: got %h want %h", f3s[i], obs_dout, exps[i]); end
            n_checks++;
            if (obs_cyc != cycs[i] || obs_err !== 1'b0) begin
                n_fail++; $display("FAIL load_f3_%0b_timing: got cycle %0d err %b want cycle %0d err 0", f3s[i], obs_cyc, obs_err, cycs[i]);
            end
        end
        n_checks++;
        if (acc_addr_q.size() != 4 || acc_addr_q[0] !== 32'h10 || acc_addr_q[1] !== 32'h11 ||
            acc_addr_q[2] !== 32'h12 || acc_addr_q[3] !== 32'h13) begin
            n_fail++; $display("FAIL lw_addr_seq: got %0d transfers want 0x10..0x13", acc_addr_q.size());
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s [3];
        int          cnt [3];
        int          cycs[3];
        logic [39:0] exp [3][4];
        bit          ok;
        f3s  = '{3'b001, 3'b000, 3'b010};
        cnt  = '{2, 1, 4};
        cycs = '{3, 2, 5};
        exp  = '{'{{32'h20, 8'hAB}, {32'h21, 8'hCD}, 40'h0, 40'h0},
                 '{{32'h20, 8'hCD}, 40'h0, 40'h0, 40'h0},
                 '{{32'h20, 8'h12}, {32'h21, 8'h34}, {32'h22, 8'hAB}, {32'h23, 8'hCD}}};
        wait_cfg = 0;
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);   // data_out = 0x80123456
        for (int s = 0; s < 3; s++) begin
            do_req(1'b0, 1'b1, f3s[s], 32'h20, 32'h1234ABCD, 1'b0);
            ok = (wlog.size() == cnt[s]);
            for (int k = 0; k < cnt[s] && ok; k++) if (wlog[k] !== exp[s][k]) ok = 1'b0;
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL store_f3_%0b_writes: got %0d writes (first %h) want %0d (first %h)", f3s[s], wlog.size(), (wlog.size() > 0) ? wlog[0] : 40'h0, cnt[s], exp[s][0]); end
            n_checks++;
            if (obs_cyc != cycs[s] || obs_err !== 1'b0) begin
                n_fail++; $display("FAIL store_f3_%0b_timing: got cycle %0d err %b want %0d err 0", f3s[s], obs_cyc, obs_err, cycs[s]);
            end
            n_checks++;
            if (obs_dout !== 32'h80123456) begin n_fail++; $display("FAIL store_f3_%0b_data_out_held: got %h want 80123456", f3s[s], obs_dout); end
        end
        ref_mem[32'h20] = 8'h12; ref_mem[32'h21] = 8'h34;
        ref_mem[32'h22] = 8'hAB; ref_mem[32'h23] = 8'hCD;
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        n_checks++;
        if (obs_dout !== 32'h1234ABCD) begin n_fail++; $display("FAIL store_readback: got %h want 1234abcd", obs_dout); end
    endtask

    task automatic test_wait_states();
        wait_cfg = 2;
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        wait_cfg = 0;
        n_checks++;
        if (obs_dout !== 32'h80123456) begin n_fail++; $display("FAIL wait_data: got %h want 80123456", obs_dout); end
        n_checks++;
        if (obs_cyc != 13) begin n_fail++; $display("FAIL wait_done_cycle: got %0d want 13", obs_cyc); end
        n_checks++;
        if (stab_err != 0) begin n_fail++; $display("FAIL wait_request_stable: got %0d changes want 0", stab_err); end
        n_checks++;
        if (acc_addr_q.size() != 4 || acc_addr_q[3] !== 32'h13) begin
            n_fail++; $display("FAIL wait_transfers: got %0d want 4", acc_addr_q.size());
        end
    endtask

    task automatic test_wrap();
        preload(32'hFFFFFFFE, 8'hA1); preload(32'hFFFFFFFF, 8'hB2);
        preload(32'h00000000, 8'hC3); preload(32'h00000001, 8'hD4);
        wait_cfg = 0;
        do_req(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b0);
        n_checks++;
        if (acc_addr_q.size() != 4 || acc_addr_q[0] !== 32'hFFFFFFFE || acc_addr_q[1] !== 32'hFFFFFFFF ||
            acc_addr_q[2] !== 32'h0 || acc_addr_q[3] !== 32'h1) begin
            n_fail++; $display("FAIL wrap_addr_seq: got %0d transfers (third %h) want fffffffe,ffffffff,0,1",
                                acc_addr_q.size(), (acc_addr_q.size() > 2) ? acc_addr_q[2] : 32'hx);
        end
        n_checks++;
        if (obs_dout !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL wrap_lw_data: got %h want a1b2c3d4", obs_dout); end
        do_req(1'b1, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b0);
        n_checks++;
        if (obs_dout !== 32'hFFFFB2C3) begin n_fail++; $display("FAIL wrap_lh_data: got %h want ffffb2c3", obs_dout); end
    endtask

    task automatic test_illegal();
        bit          rds [5];
        bit          wrs [5];
        logic [2:0]  f3s [5];
        rds = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        wrs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f3s = '{3'b011, 3'b000, 3'b010, 3'b100, 3'b111};
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);   // non-zero data_out first
        for (int i = 0; i < 5; i++) begin
            do_req(rds[i], wrs[i], f3s[i], 32'h10, 32'hFFFFFFFF, 1'b0);
            n_checks++;
            if (obs_cyc != 1 || obs_err !== 1'b1 || obs_dout !== 32'h0) begin
                n_fail++; $display("FAIL illegal_%0d: got cycle %0d err %b data %h want cycle 1 err 1 data 0", i, obs_cyc, obs_err, obs_dout);
            end
            n_checks++;
            if (any_access) begin n_fail++; $display("FAIL illegal_%0d_no_access: got memory access want none", i); end
        end
        do_req(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0);
        n_checks++;
        if (obs_err !== 1'b0 || obs_dout !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL err_cleared: got err %b data %h want err 0 data ffffff80", obs_err, obs_dout);
        end
    endtask

    task automatic test_reset_mid();
        wlog.delete();
        acc_addr_q.delete();
        wait_cfg = 0;
        @(negedge clk);
        start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b010;
        addr = 32'h30; data_in = 32'hA5B6C7D8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);            // first byte written here
        hold_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h31) begin
            n_fail++; $display("FAIL reset_mid_on_byte2: got we %b addr %h want 1 00000031", mem_we, mem_addr);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, mem_re, mem_we} !== 5'b0 || data_out !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got flags %b data %h addr %h want all 0", {busy, done, err, mem_re, mem_we}, data_out, mem_addr);
        end
        rst_n = 1'b1;
        hold_ack = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (wlog.size() != 1 || wlog[0] !== {32'h30, 8'hA5}) begin
            n_fail++; $display("FAIL reset_mid_writes: got %0d writes want 1 (a5 at 0x30)", wlog.size());
        end
        ref_mem[32'h30] = 8'hA5;
        do_req(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0);
        n_checks++;
        if (obs_dout !== 32'hFFFFFF80 || obs_cyc != 2) begin
            n_fail++; $display("FAIL after_reset_lb: got data %h cycle %0d want ffffff80 cycle 2", obs_dout, obs_cyc);
        end
    endtask

    task automatic test_start_held();
        wait_cfg = 0;
        do_req(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 1'b1);
        n_checks++;
        if (obs_cyc != 2 || obs_dout !== 32'h00000012 || acc_addr_q.size() != 1) begin
            n_fail++; $display("FAIL start_held_busy: got cycle %0d data %h transfers %0d want 2 00000012 1", obs_cyc, obs_dout, acc_addr_q.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_held_done_ignored: got busy %b want 0", busy); end
    endtask

    task automatic test_random();
        logic [31:0] model_dout;
        bit          ok;
        do_req(1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 1'b0);
        model_dout = 32'h0;
        n_checks++;
        if (obs_dout !== model_dout) begin n_fail++; $display("FAIL rand_init: got %h want 0", obs_dout); end
        for (int it = 0; it < 60; it++) begin
            bit          rd, wr, legal;
            logic [2:0]  f3;
            logic [31:0] a, d, ea;
            logic [7:0]  b;
            int          w, n, exp_cyc;
            logic [39:0] exp_log[$];
            case ($urandom_range(0, 9))
                0:         {rd, wr} = 2'b11;
                1:         {rd, wr} = 2'b00;
                2, 3, 4, 5: {rd, wr} = 2'b10;
                default:   {rd, wr} = 2'b01;
            endcase
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else case ($urandom_range(0, 4))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                            : 32'h40 + 32'($urandom_range(0, 15));
            d = $urandom;
            w = $urandom_range(0, 2);
            wait_cfg = w;
            legal = ref_legal(rd, wr, f3);
            n = ref_n(f3);
            exp_log.delete();
            if (!legal) begin
                model_dout = 32'h0;
                exp_cyc = 1;
            end else begin
                exp_cyc = 1 + n * (w + 1);
                if (rd) model_dout = ref_load(a, f3);
                else for (int i = 0; i < n; i++) begin
                    b  = 8'(d >> (8 * (n - 1 - i)));
                    ea = a + 32'(i);
                    exp_log.push_back({ea, b});
                    ref_mem[ea] = b;
                end
            end
            do_req(rd, wr, f3, a, d, 1'b0);
            n_checks++;
            if (obs_cyc != exp_cyc || obs_err !== !legal) begin
                n_fail++; $display("FAIL rand%0d_timing: got cycle %0d err %b want cycle %0d err %b", it, obs_cyc, obs_err, exp_cyc, !legal);
            end
            n_checks++;
            if (obs_dout !== model_dout) begin
                n_fail++; $display("FAIL rand%0d_data: rd %b wr %b f3 %b addr %h got %h want %h", it, rd, wr, f3, a, obs_dout, model_dout);
            end
            ok = (wlog.size() == exp_log.size());
            for (int k = 0; k < exp_log.size() && ok; k++) if (wlog[k] !== exp_log[k]) ok = 1'b0;
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand%0d_writes: got %0d writes want %0d", it, wlog.size(), exp_log.size()); end
            n_checks++;
            if (stab_err != 0 || (!legal && any_access)) begin
                n_fail++; $display("FAIL rand%0d_bus: got %0d unstable cycles, access %b on legal=%b", it, stab_err, any_access, legal);
            end
        end
        wait_cfg = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'b000; addr = 32'h0; data_in = 32'h0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        prev_wait = 1'b0; any_access = 1'b0; stab_err = 0;
        test_reset();
        test_loads();
        test_stores();
        test_wait_states();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_start_held();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
